rvfi_mem_stub: RTL
==================

# rvfi_mem_stub

Formal-verification memory stub for `riscv.Hart` harnesses. It replaces the free-running random `imem`/`dmem` data nets of the RVFI wrapper with a request/response port that has bounded, solver-chosen wait states. A small address-tagged write store makes read-after-write return the written bytes. One instance serves one memory port; the formal wrapper instantiates two, for instruction and data memory.

## Interface
- `ADDR_W`, 32: request address width.
- `DATA_W`, 32: data width; a multiple of 8. Byte lanes `NB = DATA_W/8`.
- `MAX_STALL`, 4: maximum extra wait cycles before a response is forced. 0 gives fixed latency.
- `DEPTH`, 4: write-store entries. 0 disables the store, so every read is random.
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: stub can accept a request.
- `req_addr`  in  ADDR_W: byte address; the low `log2(NB)` bits are ignored.
- `req_wmask`  in  NB: byte write enables; all-zero means read.
- `req_wdata`  in  DATA_W: write data.
- `rsp_valid`  out  1: one-cycle response strobe.
- `rsp_rdata`  out  DATA_W: read data; held stable until the next response.
- `rnd_data`  in  DATA_W: solver-driven random data (`rvformal_rand_reg` in the wrapper).
- `rnd_stall`  in  1: solver-driven stall request.
- `busy`  out  1: a transaction is in flight.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready=1`.
  - When `req_valid` is high, latch addr/wmask/wdata, clear `stall_cnt`, go to WAIT.
- **WAIT**
  - If `rnd_stall==0` or `stall_cnt==MAX_STALL`: compute read data, update the store, go to RESP.
  - Otherwise increment `stall_cnt`.
  - `stall_cnt` is `$clog2(MAX_STALL+1)` bits and never exceeds MAX_STALL.
- **RESP**
  - `rsp_valid=1`, `req_ready=0`; go to IDLE.
- **Read data, computed in WAIT on the exit cycle**
  - Word index `widx = req_addr[ADDR_W-1:log2(NB)]`.
  - On a store hit, each byte comes from the stored entry; on a miss, from `rnd_data`.
  - Write requests return the pre-write value.
- **Store update on writes (`wmask != 0`)**
  - Hit: merge only the enabled bytes into the entry.
  - Miss: allocate entry `wr_ptr`. Enabled bytes come from `req_wdata`; the others take the same `rnd_data` bytes returned this cycle. Set valid and increment `wr_ptr`, wrapping `DEPTH-1 -> 0` and overwriting the oldest entry.
- **Hit uniqueness:** at most one entry matches `widx`, because allocation happens only on a miss. Multiple hits are an internal assertion failure.
- **`busy`** = state != IDLE.
- **Reset**, asynchronous at any point including mid-transaction:
  - state IDLE; `stall_cnt`, `wr_ptr`, all valid bits and `rsp_rdata` cleared to 0.
  - An in-flight request is dropped with no response.
  - `req_ready` reads 1 while reset is held.

## Timing
- **Accept:** on the edge where `req_valid & req_ready`, at the end of cycle A.
- **Response cycle:** `rsp_valid` is high in cycle A+2+k, where k is the number of stalled WAIT cycles, 0 ≤ k ≤ MAX_STALL.
- **Latency bounds:** minimum 2 cycles, maximum MAX_STALL+2 cycles.
- **Throughput:** at most one request per 3 cycles; no pipelining.
- **Outputs:** `rsp_rdata` is registered and updates on the WAIT→RESP edge. `req_ready`, `rsp_valid` and `busy` decode directly from the state register.
- **Don't-care inputs:** `rnd_data` is sampled only on the WAIT exit cycle. `rnd_stall` is ignored outside WAIT.

## Structure
- **Package `rvfi_fv_pkg`:** `stub_state_e` (IDLE/WAIT/RESP) and the `word_index` helper. Shared with the wrapper.
- **Sub-module `rvfi_mem_store`**
  - Holds the DEPTH-entry tag/data/valid arrays and `wr_ptr`.
  - Provides a combinational lookup (hit, data) and a one-cycle update port.
  - Generates empty logic when DEPTH=0.
- **Top level:** FSM, stall counter and byte-select muxing.
- **Instantiation:** the wrapper connects `rnd_data`/`rnd_stall` to `rvformal_rand_reg` nets.

## Test plan
- **Min latency:** reset, then read 0x100 with `rnd_stall=0` and `rnd_data=0xDEADBEEF` → `rsp_valid` high exactly 2 cycles after accept, `rsp_rdata=0xDEADBEEF`, `req_ready` low for those cycles.
- **Forced response:** MAX_STALL=4, `rnd_stall` held 1 → response in cycle A+6, never later.
- **Read-after-write:**
  - Write 0x11223344 to 0x200 with mask 0xF.
  - Then read 0x200 with `rnd_data=0` → 0x11223344.
  - Then write 0xAA00_0000 with mask 0x8 and read → 0xAA223344.
- **Wrap:** DEPTH=4, writes to 5 distinct words → the first word misses and returns `rnd_data`; words 2–5 still hit.
- **Partial miss:** write mask 0x1, data 0x55, to a fresh word with `rnd_data=0x12345678` → later read returns 0x12345655.
- **Reset mid-WAIT:** assert `reset` during a stalled WAIT → no `rsp_valid` follows, `rsp_rdata=0`, store empty, `req_ready=1`.

Source files
------------

// File: rtl/rvfi_fv_pkg.sv
// Shared types and helpers for the riscv.Hart formal wrapper and its
// memory stubs.
//   stub_state_e : request/response FSM state of rvfi_mem_stub
//   word_index   : byte address -> word index (drops the byte-lane bits)
package rvfi_fv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } stub_state_e;

   // Width-agnostic: callers zero-extend the address to 64 bits and keep
   // the low bits of the result that they need.
   function automatic logic [63:0] word_index(input logic [63:0] addr,
                                              input int unsigned lane_bits);
      return addr >> lane_bits;
   endfunction

endpackage

// File: rtl/rvfi_mem_store.sv
// Address-tagged write store used by rvfi_mem_stub so that read-after-write
// returns the written bytes instead of fresh solver data.
//   clock, reset : clock and asynchronous active-high reset
//   lookup_idx   : word index to look up (also the update target tag)
//   lookup_hit   : a valid entry holds lookup_idx
//   lookup_data  : data of the hitting entry, zero on a miss
//   upd_en       : write upd_data for lookup_idx this cycle
//   upd_data     : fully merged word to store
// On a hit the matching entry is rewritten; on a miss entry wr_ptr is
// allocated and wr_ptr advances, so the oldest allocation is replaced.
module rvfi_mem_store #(
   parameter int IDX_W  = 30,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [IDX_W-1:0]  lookup_idx,
   output logic              lookup_hit,
   output logic [DATA_W-1:0] lookup_data,
   input  logic              upd_en,
   input  logic [DATA_W-1:0] upd_data
);

   generate
      if (DEPTH == 0) begin : g_none
         logic unused_store_in;
         assign unused_store_in = ^{clock, reset, lookup_idx, upd_en, upd_data};
         assign lookup_hit  = 1'b0;
         assign lookup_data = '0;
      end else begin : g_store
         localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

         logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
         logic [DEPTH-1:0]  valid_q, valid_d;
         logic [IDX_W-1:0]  tag_q  [DEPTH];
         logic [IDX_W-1:0]  tag_d  [DEPTH];
         logic [DATA_W-1:0] data_q [DEPTH];
         logic [DATA_W-1:0] data_d [DEPTH];
         logic [DEPTH-1:0]  hit_vec;
         logic              any_hit;
         logic [DATA_W-1:0] hit_data;

         // Allocation only happens on a miss, so hit_vec is at most one-hot
         // and an OR-reduction selects the hitting entry.
         always_comb begin
            hit_vec  = '0;
            hit_data = '0;
            for (int i = 0; i < DEPTH; i++) begin
               hit_vec[i] = valid_q[i] && (tag_q[i] == lookup_idx);
               if (hit_vec[i]) hit_data = hit_data | data_q[i];
            end
            any_hit = |hit_vec;
         end

         assign lookup_hit  = any_hit;
         assign lookup_data = hit_data;

         always_comb begin
            valid_d  = valid_q;
            wr_ptr_d = wr_ptr_q;
            for (int i = 0; i < DEPTH; i++) begin
               tag_d[i]  = tag_q[i];
               data_d[i] = data_q[i];
               if (upd_en && (any_hit ? hit_vec[i] : (wr_ptr_q == PTR_W'(i)))) begin
                  valid_d[i] = 1'b1;
                  tag_d[i]   = lookup_idx;
                  data_d[i]  = upd_data;
               end
            end
            if (upd_en && !any_hit)
               wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         end

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               wr_ptr_q <= '0;
               valid_q  <= '0;
               for (int i = 0; i < DEPTH; i++) begin
                  tag_q[i]  <= '0;
                  data_q[i] <= '0;
               end
            end else begin
               wr_ptr_q <= wr_ptr_d;
               valid_q  <= valid_d;
               for (int i = 0; i < DEPTH; i++) begin
                  tag_q[i]  <= tag_d[i];
                  data_q[i] <= data_d[i];
               end
            end
         end

`ifndef SYNTHESIS
         hit_unique: assert property (@(posedge clock) disable iff (reset)
                                      $onehot0(hit_vec));
`endif
      end
   endgenerate

endmodule

// File: rtl/rvfi_mem_stub.sv
// Formal memory stub: request/response port with bounded solver-chosen
// wait states; read data comes from the write store on a hit, otherwise
// from solver-driven rnd_data.
//   clock, reset            : clock, asynchronous active-high reset
//   req_valid/req_ready     : request handshake
//   req_addr/wmask/wdata    : byte address, byte enables (0 = read), data
//   rsp_valid/rsp_rdata     : one-cycle response strobe, held read data
//   rnd_data/rnd_stall      : solver-driven data and stall request
//   busy                    : a transaction is in flight
module rvfi_mem_stub
   import rvfi_fv_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_STALL = 4,
   parameter int DEPTH     = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W/8-1:0] req_wmask,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   input  logic [DATA_W-1:0]   rnd_data,
   input  logic                rnd_stall,
   output logic                busy
);

   localparam int NB      = DATA_W / 8;
   localparam int NB_LOG2 = (NB > 1) ? $clog2(NB) : 0;
   localparam int IDX_W   = ADDR_W - NB_LOG2;
   localparam int SC_W    = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;

   stub_state_e       state_q, state_d;
   logic [SC_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [NB-1:0]     wmask_q, wmask_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

   logic [63:0]       widx_full;
   logic [IDX_W-1:0]  widx;
   logic              unused_widx;
   logic              store_hit;
   logic [DATA_W-1:0] store_data;
   logic              store_upd;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] new_word;

   assign widx_full   = word_index(64'(addr_q), NB_LOG2);
   assign widx        = widx_full[IDX_W-1:0];
   assign unused_widx = ^(widx_full >> IDX_W);

   // Read data is the pre-write value; the store is refilled with the
   // same word after the enabled bytes are merged in. On a miss the
   // unwritten bytes therefore keep the rnd_data returned this cycle.
   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_lane
         assign rd_word[8*gi +: 8]  = store_hit ? store_data[8*gi +: 8]
                                                : rnd_data[8*gi +: 8];
         assign new_word[8*gi +: 8] = wmask_q[gi] ? wdata_q[8*gi +: 8]
                                                  : rd_word[8*gi +: 8];
      end
   endgenerate

   rvfi_mem_store #(
      .IDX_W  (IDX_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_store (
      .clock       (clock),
      .reset       (reset),
      .lookup_idx  (widx),
      .lookup_hit  (store_hit),
      .lookup_data (store_data),
      .upd_en      (store_upd),
      .upd_data    (new_word)
   );

   always_comb begin
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;
      addr_d      = addr_q;
      wmask_d     = wmask_q;
      wdata_d     = wdata_q;
      rsp_rdata_d = rsp_rdata_q;
      store_upd   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d      = req_addr;
               wmask_d     = req_wmask;
               wdata_d     = req_wdata;
               stall_cnt_d = '0;
               state_d     = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!rnd_stall || (stall_cnt_q == SC_W'(MAX_STALL))) begin
               rsp_rdata_d = rd_word;
               store_upd   = |wmask_q;
               state_d     = ST_RESP;
            end else begin
               stall_cnt_d = stall_cnt_q + 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         stall_cnt_q <= '0;
         addr_q      <= '0;
         wmask_q     <= '0;
         wdata_q     <= '0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         addr_q      <= addr_d;
         wmask_q     <= wmask_d;
         wdata_q     <= wdata_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign busy      = (state_q != ST_IDLE);
   assign rsp_rdata = rsp_rdata_q;

endmodule
